// File: rtl/eth_rx_burst_writer.sv
// eth_rx_burst_writer: MII receive parser that packs frame payload into big-endian words and writes them to incrementing addresses in bursts
module eth_rx_burst_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 24,
  parameter int WORDS_PER_PKT = 256,
  parameter int PKTS_PER_BURST = 1024,
  parameter logic [15:0] TYPE_MATCH = 16'h88B5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  Start_I,
  input  logic [ADDR_WIDTH-1:0] Base_I,
  input  logic [3:0]            RX_DATA_I,
  input  logic                  RX_DV_I,
  input  logic                  RX_ER_I,
  output logic [ADDR_WIDTH-1:0] Address_O,
  output logic [DATA_WIDTH-1:0] RX_data_O,
  output logic                  RX_write_en_O,
  output logic [47:0]           Src_MAC_O,
  output logic [15:0]           Type_O,
  output logic                  Type_valid_O,
  output logic                  Active_rx_O,
  output logic                  Busy_O,
  output logic                  Burst_done_O,
  output logic                  Error_O
);
  localparam int NPW = DATA_WIDTH / 4;
  localparam int NW = $clog2(NPW);
  localparam int WW = WORDS_PER_PKT > 1 ? $clog2(WORDS_PER_PKT) : 1;
  localparam int PW = $clog2(PKTS_PER_BURST + 1);
  localparam logic [NW-1:0] NIB_LAST = NW'(NPW - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(WORDS_PER_PKT - 1);
  localparam logic [PW-1:0] PKT_LAST = PW'(PKTS_PER_BURST - 1);

  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, TRAIL, DROP} state_t;

  state_t                  state;
  logic [4:0]              hcnt;
  logic [NW-1:0]           ncnt;
  logic [WW-1:0]           wcnt;
  logic [PW-1:0]           pcnt;
  logic [3:0]              lo;
  logic [47:0]             src;
  logic [7:0]              type_hi;
  logic [DATA_WIDTH-1:0]   word;
  logic [ADDR_WIDTH-1:0]   frame_base;
  logic                    last_pending;
  logic [7:0]              byte_in;
  logic [DATA_WIDTH-1:0]   word_next;
  logic                    abort;

  assign byte_in = {RX_DATA_I, lo};
  assign word_next = (word << 8) | DATA_WIDTH'(byte_in);
  assign abort = !RX_DV_I || RX_ER_I;
  assign Active_rx_O = state != IDLE;

  // Frame parser, word packer, write strobe, address and burst bookkeeping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      hcnt          <= '0;
      ncnt          <= '0;
      wcnt          <= '0;
      pcnt          <= '0;
      lo            <= '0;
      src           <= '0;
      type_hi       <= '0;
      word          <= '0;
      frame_base    <= '0;
      last_pending  <= 1'b0;
      Address_O     <= '0;
      RX_data_O     <= '0;
      RX_write_en_O <= 1'b0;
      Src_MAC_O     <= '0;
      Type_O        <= '0;
      Type_valid_O  <= 1'b0;
      Busy_O        <= 1'b0;
      Burst_done_O  <= 1'b0;
      Error_O       <= 1'b0;
    end else begin
      RX_write_en_O <= 1'b0;
      Burst_done_O  <= 1'b0;
      Error_O       <= 1'b0;
      last_pending  <= 1'b0;
      if (RX_write_en_O) Address_O <= Address_O + 1'b1;
      if (last_pending) begin
        pcnt <= pcnt + 1'b1;
        if (pcnt == PKT_LAST) begin
          Burst_done_O <= 1'b1;
          Busy_O       <= 1'b0;
        end
      end
      if (Start_I) begin
        Busy_O       <= 1'b1;
        Burst_done_O <= 1'b0;
        Address_O    <= Base_I;
        pcnt         <= '0;
        state        <= (state == IDLE) ? IDLE : DROP;
      end else begin
        case (state)
          IDLE: begin
            Type_valid_O <= 1'b0;
            if (RX_DV_I) state <= Busy_O ? PREAMBLE : DROP;
          end
          PREAMBLE: begin
            if (abort) begin
              Error_O <= 1'b1;
              state   <= RX_DV_I ? DROP : IDLE;
            end else if (RX_DATA_I == 4'hD) begin
              state <= HEADER;
              hcnt  <= '0;
            end
          end
          HEADER: begin
            if (abort) begin
              Error_O <= 1'b1;
              state   <= RX_DV_I ? DROP : IDLE;
            end else begin
              hcnt <= hcnt + 1'b1;
              lo   <= RX_DATA_I;
              if (hcnt[0] && hcnt >= 5'd13 && hcnt <= 5'd23) src <= {src[39:0], byte_in};
              if (hcnt == 5'd25) type_hi <= byte_in;
              if (hcnt == 5'd27) begin
                Type_O       <= {type_hi, byte_in};
                Type_valid_O <= 1'b1;
                state        <= ({type_hi, byte_in} == TYPE_MATCH) ? PAYLOAD : DROP;
                ncnt         <= '0;
                wcnt         <= '0;
                frame_base   <= Address_O;
              end
            end
          end
          PAYLOAD: begin
            if (abort) begin
              Error_O   <= 1'b1;
              Address_O <= frame_base;
              state     <= RX_DV_I ? DROP : IDLE;
            end else begin
              lo   <= RX_DATA_I;
              ncnt <= ncnt + 1'b1;
              if (ncnt[0]) word <= word_next;
              if (ncnt == NIB_LAST) begin
                ncnt          <= '0;
                RX_data_O     <= word_next;
                RX_write_en_O <= 1'b1;
                wcnt          <= wcnt + 1'b1;
                if (wcnt == WORD_LAST) begin
                  last_pending <= 1'b1;
                  Src_MAC_O    <= src;
                  state        <= TRAIL;
                end
              end
            end
          end
          TRAIL, DROP: if (!RX_DV_I) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_eth_rx_burst_writer.sv
// tb_eth_rx_burst_writer: scoreboard bench driving MII frames and checking every write, pulse and status output
module tb_eth_rx_burst_writer;
  localparam int PKTS = 2;
  localparam int WORDS = 256;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        Start_I = 1'b0;
  logic [23:0] Base_I = '0;
  logic [3:0]  RX_DATA_I = '0;
  logic        RX_DV_I = 1'b0;
  logic        RX_ER_I = 1'b0;
  logic [23:0] Address_O;
  logic [31:0] RX_data_O;
  logic        RX_write_en_O;
  logic [47:0] Src_MAC_O;
  logic [15:0] Type_O;
  logic        Type_valid_O;
  logic        Active_rx_O;
  logic        Busy_O;
  logic        Burst_done_O;
  logic        Error_O;

  eth_rx_burst_writer #(.PKTS_PER_BURST(PKTS)) dut (
    .clock(clock), .reset(reset), .Start_I(Start_I), .Base_I(Base_I),
    .RX_DATA_I(RX_DATA_I), .RX_DV_I(RX_DV_I), .RX_ER_I(RX_ER_I),
    .Address_O(Address_O), .RX_data_O(RX_data_O), .RX_write_en_O(RX_write_en_O),
    .Src_MAC_O(Src_MAC_O), .Type_O(Type_O), .Type_valid_O(Type_valid_O),
    .Active_rx_O(Active_rx_O), .Busy_O(Busy_O), .Burst_done_O(Burst_done_O), .Error_O(Error_O)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int n_err = 0;
  int n_done = 0;
  int m_err = 0;
  int m_done = 0;
  int m_cnt = 0;
  logic        m_busy = 1'b0;
  logic [23:0] m_addr = '0;
  logic [47:0] m_src = '0;
  logic [55:0] sb[$];
  logic        prev_we = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard pop on each strobe, plus pulse counting
  always @(negedge clock) begin
    if (!reset) begin
      if (RX_write_en_O) begin
        if (sb.size() == 0) chk("spurious_write", {40'd0, Address_O}, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          logic [55:0] e;
          e = sb.pop_front();
          chk("wr_addr", {40'd0, Address_O}, {40'd0, e[55:32]});
          chk("wr_data", {32'd0, RX_data_O}, {32'd0, e[31:0]});
        end
      end
      if (Burst_done_O) begin
        n_done++;
        chk("done_after_strobe", {63'd0, prev_we}, 64'd1);
      end
      if (Error_O) n_err++;
      prev_we = RX_write_en_O;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic zero_chk(input string tag);
    chk({tag, "_addr"}, {40'd0, Address_O}, 64'd0);
    chk({tag, "_data"}, {32'd0, RX_data_O}, 64'd0);
    chk({tag, "_src"}, {16'd0, Src_MAC_O}, 64'd0);
    chk({tag, "_type"}, {48'd0, Type_O}, 64'd0);
    chk({tag, "_flags"}, {58'd0, RX_write_en_O, Type_valid_O, Active_rx_O, Busy_O, Burst_done_O, Error_O}, 64'd0);
  endtask

  task automatic nib(input logic [3:0] d, input logic dv);
    @(negedge clock);
    RX_DATA_I = d;
    RX_DV_I = dv;
  endtask

  task automatic send_byte(input logic [7:0] b);
    nib(b[3:0], 1'b1);
    nib(b[7:4], 1'b1);
  endtask

  task automatic start(input logic [23:0] base);
    @(negedge clock);
    Start_I = 1'b1;
    Base_I = base;
    @(negedge clock);
    Start_I = 1'b0;
    m_busy = 1'b1;
    m_addr = base;
    m_cnt = 0;
    chk("busy_after_start", {63'd0, Busy_O}, 64'd1);
  endtask

  // stop_at >= 0: drop RX_DV_I (or assert reset when do_rst) before that payload word
  task automatic frame(input logic [15:0] typ, input logic [47:0] src, input int stop_at, input bit do_rst);
    logic accept;
    logic aborted;
    logic [31:0] d;
    accept = m_busy && typ == 16'h88B5;
    aborted = 1'b0;
    for (int i = 0; i < 15; i++) nib(4'h5, 1'b1);
    nib(4'hD, 1'b1);
    for (int i = 5; i >= 0; i--) send_byte(8'hA0 + 8'(i));
    for (int i = 5; i >= 0; i--) send_byte(src[8*i +: 8]);
    send_byte(typ[15:8]);
    send_byte(typ[7:0]);
    if (m_busy) begin
      @(posedge clock);
      #1;
      chk("type", {48'd0, Type_O}, {48'd0, typ});
      chk("type_valid", {62'd0, Type_valid_O, Active_rx_O}, 64'd3);
    end
    for (int w = 0; w < WORDS; w++) begin
      if (w == stop_at) begin
        if (do_rst) begin
          @(negedge clock);
          #2 reset = 1'b1;
          #1 zero_chk("rst_mid");
          @(negedge clock);
          reset = 1'b0;
          accept = 1'b0;
          m_busy = 1'b0;
          m_addr = '0;
          m_cnt = 0;
          m_src = '0;
        end else begin
          aborted = 1'b1;
          break;
        end
      end
      d = {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
      for (int b = 3; b >= 0; b--) send_byte(d[8*b +: 8]);
      if (accept) sb.push_back({m_addr + 24'(w), d});
    end
    if (!aborted) for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i));
    for (int i = 0; i < 5; i++) nib(4'h0, 1'b0);
    if (accept && aborted) m_err++;
    if (accept && !aborted) begin
      m_addr = m_addr + 24'(WORDS);
      m_src = src;
      m_cnt++;
      if (m_cnt == PKTS) begin
        m_busy = 1'b0;
        m_done++;
      end
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("err_count", 64'(n_err), 64'(m_err));
    chk("done_count", 64'(n_done), 64'(m_done));
    chk("addr_end", {40'd0, Address_O}, {40'd0, m_addr});
    chk("busy", {63'd0, Busy_O}, {63'd0, m_busy});
    chk("src_mac", {16'd0, Src_MAC_O}, {16'd0, m_src});
    chk("idle_flags", {62'd0, Type_valid_O, Active_rx_O}, 64'd0);
  endtask

  initial begin
    #22 zero_chk("reset");
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    zero_chk("post_reset");
    start(24'h000100);
    frame(16'h88B5, 48'h020000000001, -1, 1'b0);
    frame(16'h0800, 48'h020000000002, -1, 1'b0);
    frame(16'h88B5, 48'h020000000003, 10, 1'b0);
    frame(16'h88B5, 48'h020000000004, -1, 1'b0);
    start(24'h001000);
    frame(16'h88B5, 48'h020000000005, -1, 1'b0);
    frame(16'h88B5, 48'h020000000006, -1, 1'b0);
    frame(16'h88B5, 48'h020000000007, -1, 1'b0);
    start(24'hFFFFFE);
    frame(16'h88B5, 48'h020000000008, -1, 1'b0);
    start(24'h000400);
    frame(16'h88B5, 48'h020000000009, 5, 1'b1);
    frame(16'h88B5, 48'h02000000000A, -1, 1'b0);
    repeat (4) @(negedge clock);
    zero_chk("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
